// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: counting mode and direction encodings.
package counter_pkg;

  localparam logic COUNT_WRAP = 1'b0;
  localparam logic COUNT_SAT  = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/counter_step.sv
// Combinational single-step of the counter: next value and boundary detection,
// computed at WIDTH+1 bits so carry/borrow out of the register width is visible.
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH - 1
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             dir_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             boundary_hit_o
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_COUNT);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum            = {1'b0, count_i} + (WIDTH+1)'(1);
    diff           = {1'b0, count_i} - (WIDTH+1)'(1);
    next_o         = count_i;
    boundary_hit_o = 1'b0;
    if (dir_i == DIR_UP) begin
      // Stepping past MAX_COUNT is the up boundary, even when MAX_COUNT < 2**WIDTH-1.
      if (sum > MAX_EXT) begin
        boundary_hit_o = 1'b1;
        next_o         = (mode_i == COUNT_SAT) ? MAX_W : '0;
      end else begin
        next_o = sum[WIDTH-1:0];
      end
    end else begin
      // A borrow out of the extra bit means we were at zero.
      if (diff[WIDTH]) begin
        boundary_hit_o = 1'b1;
        next_o         = (mode_i == COUNT_SAT) ? '0 : MAX_W;
      end else begin
        next_o = diff[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable modulus, synchronous load, wrap/saturate mode,
// registered terminal-count pulse and sticky overflow/underflow flags.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MAX_COUNT   = 2**WIDTH - 1,
  parameter bit SATURATE    = 1'b0,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] counter_out,
  output logic             tc,
  output logic             overflow,
  output logic             underflow
);

  if (WIDTH < 2) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be at least 2");
  end
  if (MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH - 1) begin : g_bad_max
    $error("mod_updown_counter: MAX_COUNT out of range for WIDTH");
  end
  if (RESET_VALUE < 0 || RESET_VALUE > MAX_COUNT) begin : g_bad_reset
    $error("mod_updown_counter: RESET_VALUE must lie in 0..MAX_COUNT");
  end

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VALUE);
  localparam logic             MODE    = SATURATE ? COUNT_SAT : COUNT_WRAP;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] step_next;
  logic             step_hit;
  logic [WIDTH-1:0] load_clamped;

  counter_step #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT)
  ) u_step (
    .count_i        (count_q),
    .dir_i          (up_down),
    .mode_i         (MODE),
    .next_o         (step_next),
    .boundary_hit_o (step_hit)
  );

  assign load_clamped = ({1'b0, load_value} > MAX_EXT) ? MAX_W : load_value;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    // Clear is applied first so a same-cycle set event overrides it.
    if (clear_flags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (load) begin
      count_d = load_clamped;
    end else if (enable) begin
      count_d = step_next;
      tc_d    = step_hit;
      if (step_hit && up_down == DIR_UP)   ovf_d = 1'b1;
      if (step_hit && up_down == DIR_DOWN) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_W;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign counter_out = count_q;
  assign tc          = tc_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: three configurations share one stimulus bus.
module tb_mod_updown_counter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [7:0] load_value;
  logic       clear_flags;

  // w: WIDTH=4 MAX=9 wrap RV=0; s: WIDTH=4 MAX=9 saturate RV=3; b: WIDTH=8 default MAX wrap
  logic [3:0] cw, cs;
  logic [7:0] cb;
  logic       tcw, ow, uw, tcs, os, us, tcb, ob, ub;

  int n_checks;
  int n_fail;

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0), .RESET_VALUE(0)) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value[3:0]), .clear_flags(clear_flags),
    .counter_out(cw), .tc(tcw), .overflow(ow), .underflow(uw)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1), .RESET_VALUE(3)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value[3:0]), .clear_flags(clear_flags),
    .counter_out(cs), .tc(tcs), .overflow(os), .underflow(us)
  );

  mod_updown_counter #(.WIDTH(8), .SATURATE(1'b0), .RESET_VALUE(0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear_flags(clear_flags),
    .counter_out(cb), .tc(tcb), .overflow(ob), .underflow(ub)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; enable = 1'b0; up_down = 1'b1; load = 1'b0;
    load_value = 8'd0; clear_flags = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (cw !== 4'd0) begin n_fail++; $display("FAIL reset_w_count got=%0d want=0", cw); end
    n_checks++; if ({tcw, ow, uw} !== 3'b000) begin n_fail++; $display("FAIL reset_w_flags got=%b want=000", {tcw, ow, uw}); end
    n_checks++; if (cs !== 4'd3) begin n_fail++; $display("FAIL reset_s_count got=%0d want=3", cs); end
    n_checks++; if ({tcs, os, us} !== 3'b000) begin n_fail++; $display("FAIL reset_s_flags got=%b want=000", {tcs, os, us}); end
    n_checks++; if (cb !== 8'd0) begin n_fail++; $display("FAIL reset_b_count got=%0d want=0", cb); end
  endtask

  task automatic test_wrap_up();
    int exp_c;
    do_reset();
    enable = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_c = i % 10;
      n_checks++; if (cw !== 4'(exp_c)) begin n_fail++; $display("FAIL wrap_up_count i=%0d got=%0d want=%0d", i, cw, exp_c); end
      n_checks++; if (tcw !== (i == 10)) begin n_fail++; $display("FAIL wrap_up_tc i=%0d got=%b want=%b", i, tcw, (i == 10)); end
      n_checks++; if (ow !== (i >= 10)) begin n_fail++; $display("FAIL wrap_up_ovf i=%0d got=%b want=%b", i, ow, (i >= 10)); end
      n_checks++; if (uw !== 1'b0) begin n_fail++; $display("FAIL wrap_up_unf i=%0d got=%b want=0", i, uw); end
    end
    idle_inputs();
  endtask

  task automatic test_wrap_down();
    do_reset();
    enable = 1'b1; up_down = 1'b0;
    step();
    n_checks++; if (cw !== 4'd9) begin n_fail++; $display("FAIL down_wrap_count got=%0d want=9", cw); end
    n_checks++; if (tcw !== 1'b1) begin n_fail++; $display("FAIL down_wrap_tc got=%b want=1", tcw); end
    n_checks++; if ({ow, uw} !== 2'b01) begin n_fail++; $display("FAIL down_wrap_flags got=%b want=01", {ow, uw}); end
    step();
    n_checks++; if (cw !== 4'd8 || tcw !== 1'b0) begin n_fail++; $display("FAIL down_step count=%0d tc=%b want 8/0", cw, tcw); end
    enable = 1'b0; load = 1'b1; load_value = 8'd0;
    step();
    n_checks++; if (cw !== 4'd0 || uw !== 1'b1) begin n_fail++; $display("FAIL down_load0 count=%0d unf=%b want 0/1", cw, uw); end
    load = 1'b0; enable = 1'b1; up_down = 1'b0; clear_flags = 1'b1;
    step();
    n_checks++; if (cw !== 4'd9 || tcw !== 1'b1) begin n_fail++; $display("FAIL down_setwins count=%0d tc=%b want 9/1", cw, tcw); end
    n_checks++; if (uw !== 1'b1) begin n_fail++; $display("FAIL down_setwins_unf got=%b want=1", uw); end
    enable = 1'b0;
    step();
    n_checks++; if ({ow, uw} !== 2'b00) begin n_fail++; $display("FAIL clear_flags got=%b want=00", {ow, uw}); end
    n_checks++; if (cw !== 4'd9 || tcw !== 1'b0) begin n_fail++; $display("FAIL clear_hold count=%0d tc=%b want 9/0", cw, tcw); end
    idle_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    enable = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      n_checks++; if (cs !== 4'((i <= 6) ? (3 + i) : 9)) begin n_fail++; $display("FAIL sat_count i=%0d got=%0d want=%0d", i, cs, (i <= 6) ? (3 + i) : 9); end
      n_checks++; if (tcs !== (i >= 7)) begin n_fail++; $display("FAIL sat_tc i=%0d got=%b want=%b", i, tcs, (i >= 7)); end
      n_checks++; if (os !== (i >= 7)) begin n_fail++; $display("FAIL sat_ovf i=%0d got=%b want=%b", i, os, (i >= 7)); end
    end
    up_down = 1'b0;
    step();
    n_checks++; if (cs !== 4'd8 || tcs !== 1'b0) begin n_fail++; $display("FAIL sat_turn count=%0d tc=%b want 8/0", cs, tcs); end
    load = 1'b1; load_value = 8'd0; enable = 1'b0;
    step();
    load = 1'b0; enable = 1'b1; up_down = 1'b0;
    step();
    n_checks++; if (cs !== 4'd0 || tcs !== 1'b1 || us !== 1'b1) begin n_fail++; $display("FAIL sat_low count=%0d tc=%b unf=%b want 0/1/1", cs, tcs, us); end
    idle_inputs();
  endtask

  task automatic test_load_clamp();
    do_reset();
    load = 1'b1; load_value = 8'd14;
    step();
    n_checks++; if (cw !== 4'd9) begin n_fail++; $display("FAIL load_clamp_w got=%0d want=9", cw); end
    n_checks++; if (cs !== 4'd9) begin n_fail++; $display("FAIL load_clamp_s got=%0d want=9", cs); end
    enable = 1'b1; up_down = 1'b1;
    step();
    n_checks++; if (cw !== 4'd9 || tcw !== 1'b0 || ow !== 1'b0) begin n_fail++; $display("FAIL load_wins count=%0d tc=%b ovf=%b want 9/0/0", cw, tcw, ow); end
    load_value = 8'd5;
    step();
    n_checks++; if (cw !== 4'd5 || tcw !== 1'b0) begin n_fail++; $display("FAIL load_mid count=%0d tc=%b want 5/0", cw, tcw); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    load = 1'b1; load_value = 8'd5;
    step();
    load = 1'b0; enable = 1'b1; up_down = 1'b1; reset = 1'b1;
    step();
    n_checks++; if (cs !== 4'd3 || tcs !== 1'b0) begin n_fail++; $display("FAIL reset_mid count=%0d tc=%b want 3/0", cs, tcs); end
    reset = 1'b0; enable = 1'b0; load = 1'b1; load_value = 8'd9;
    step();
    load = 1'b0; enable = 1'b1; up_down = 1'b1;
    step();
    n_checks++; if (os !== 1'b1 || tcs !== 1'b1) begin n_fail++; $display("FAIL pre_reset_boundary ovf=%b tc=%b want 1/1", os, tcs); end
    reset = 1'b1;
    step();
    n_checks++; if (cs !== 4'd3) begin n_fail++; $display("FAIL reset_boundary_count got=%0d want=3", cs); end
    n_checks++; if ({tcs, os, us} !== 3'b000) begin n_fail++; $display("FAIL reset_boundary_flags got=%b want=000", {tcs, os, us}); end
    idle_inputs();
  endtask

  task automatic test_wide();
    do_reset();
    load = 1'b1; load_value = 8'd255;
    step();
    n_checks++; if (cb !== 8'd255) begin n_fail++; $display("FAIL wide_load got=%0d want=255", cb); end
    load = 1'b0; enable = 1'b1; up_down = 1'b1;
    step();
    n_checks++; if (cb !== 8'd0 || tcb !== 1'b1 || ob !== 1'b1) begin n_fail++; $display("FAIL wide_wrap count=%0d tc=%b ovf=%b want 0/1/1", cb, tcb, ob); end
    step();
    n_checks++; if (cb !== 8'd1 || tcb !== 1'b0) begin n_fail++; $display("FAIL wide_step count=%0d tc=%b want 1/0", cb, tcb); end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (cb !== 8'd1 || tcb !== 1'b0) begin n_fail++; $display("FAIL wide_hold i=%0d count=%0d tc=%b want 1/0", i, cb, tcb); end
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    repeat (2) step();
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_clamp();
    test_reset_mid();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
